// File: rtl/fdtd_sweep_ctrl.sv
// Sequencer for a 1-D FDTD update: per timestep it sweeps the Hy and Ez updates and
// the source injection, and issues write-backs aligned with the datapath latency.
module fdtd_sweep_ctrl #(
  parameter int N_CELLS  = 64,
  parameter int ADDR_W   = 6,
  parameter int STEP_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int CALC_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [STEP_W-1:0] num_steps_i,
  input  logic [ADDR_W-1:0] src_idx_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [STEP_W-1:0] step_o,
  output logic [ADDR_W-1:0] hy_rd_addr_o,
  output logic [ADDR_W-1:0] ez_rd_addr_o,
  output logic              calc_Hy_en_o,
  output logic              calc_Ez_en_o,
  output logic              calc_src_en_o,
  output logic              hy_we_o,
  output logic [ADDR_W-1:0] hy_wr_addr_o,
  output logic              ez_we_o,
  output logic [ADDR_W-1:0] ez_wr_addr_o
);

  localparam int L     = RD_LAT + CALC_LAT;
  localparam int CNT_W = $clog2(N_CELLS + L);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N_CELLS - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(L - 1);

  typedef enum logic [2:0] {
    IDLE, HY_RUN, HY_DRAIN, EZ_RUN, EZ_DRAIN, SRC_RUN, SRC_DRAIN, STEP_END
  } state_t;

  typedef struct packed {
    logic              hy;
    logic              ez;
    logic              src;
    logic [ADDR_W-1:0] addr;
  } wb_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_k;
  logic [STEP_W-1:0] r_num;
  logic [ADDR_W-1:0] r_src;
  logic [STEP_W-1:0] w_step_nx;
  wb_t               w_iss;
  wb_t               r_pipe [1:L];

  assign w_step_nx = step_o + STEP_W'(1);

  // Issue-stage tag: what the datapath will produce for this cycle's reads.
  always_comb begin
    w_iss = '0;
    case (r_state)
      HY_RUN: if (r_k != '0) begin
        w_iss.hy   = 1'b1;
        w_iss.addr = ADDR_W'(r_k - CNT_W'(1));
      end
      EZ_RUN: if (r_k != '0) begin
        w_iss.ez   = 1'b1;
        w_iss.addr = ADDR_W'(r_k);
      end
      SRC_RUN: begin
        w_iss.src  = 1'b1;
        w_iss.addr = r_src;
      end
      default: ;
    endcase
  end

  // Write-back tags travel unchanged; enables tap at RD_LAT, writes at L.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 1; i <= L; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[1] <= w_iss;
      for (int i = 2; i <= L; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign calc_Hy_en_o  = r_pipe[RD_LAT].hy;
  assign calc_Ez_en_o  = r_pipe[RD_LAT].ez;
  assign calc_src_en_o = r_pipe[RD_LAT].src;
  assign hy_we_o       = r_pipe[L].hy;
  assign ez_we_o       = r_pipe[L].ez | r_pipe[L].src;
  assign hy_wr_addr_o  = hy_we_o ? r_pipe[L].addr : '0;
  assign ez_wr_addr_o  = ez_we_o ? r_pipe[L].addr : '0;

  // Read addresses are registered one step ahead so they line up with r_state/r_k.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_num        <= '0;
      r_src        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      step_o       <= '0;
      hy_rd_addr_o <= '0;
      ez_rd_addr_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: if (start_i) begin
          if (num_steps_i != '0) begin
            r_num        <= num_steps_i;
            r_src        <= src_idx_i;
            busy_o       <= 1'b1;
            step_o       <= '0;
            r_k          <= '0;
            hy_rd_addr_o <= '0;
            ez_rd_addr_o <= '0;
            r_state      <= HY_RUN;
          end else begin
            done_o <= 1'b1;
          end
        end
        HY_RUN: begin
          if (r_k == K_LAST) begin
            r_k          <= '0;
            hy_rd_addr_o <= '0;
            ez_rd_addr_o <= '0;
            r_state      <= HY_DRAIN;
          end else begin
            r_k          <= r_k + CNT_W'(1);
            hy_rd_addr_o <= ADDR_W'(r_k);
            ez_rd_addr_o <= ADDR_W'(r_k + CNT_W'(1));
          end
        end
        HY_DRAIN: begin
          r_k <= r_k + CNT_W'(1);
          if (r_k == D_LAST) begin
            r_k     <= '0;
            r_state <= EZ_RUN;
          end
        end
        EZ_RUN: begin
          if (r_k == K_LAST) begin
            r_k          <= '0;
            hy_rd_addr_o <= '0;
            ez_rd_addr_o <= '0;
            r_state      <= EZ_DRAIN;
          end else begin
            r_k          <= r_k + CNT_W'(1);
            hy_rd_addr_o <= ADDR_W'(r_k + CNT_W'(1));
            ez_rd_addr_o <= ADDR_W'(r_k + CNT_W'(1));
          end
        end
        EZ_DRAIN: begin
          r_k <= r_k + CNT_W'(1);
          if (r_k == D_LAST) begin
            r_k          <= '0;
            ez_rd_addr_o <= r_src;
            r_state      <= SRC_RUN;
          end
        end
        SRC_RUN: begin
          r_k          <= '0;
          ez_rd_addr_o <= '0;
          r_state      <= SRC_DRAIN;
        end
        SRC_DRAIN: begin
          r_k <= r_k + CNT_W'(1);
          if (r_k == D_LAST) begin
            r_k     <= '0;
            r_state <= STEP_END;
          end
        end
        STEP_END: begin
          step_o <= w_step_nx;
          if (w_step_nx == r_num || stop_i) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= HY_RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
